counter_sweep_seq: RTL and testbench

Sequencer that walks the external counter ICs through a full count sweep for the ASIC tester. Drives the ADVANCE_COUNTER / RESET_COUNTER request inputs of the counter controller with guaranteed pulse widths and gaps. After each counter step it waits a programmable settle time, then hands a sample request to the test FSM. Sits between the top-level test FSM and the counter controller.

---
 rtl/counter_seq_pkg.sv | 23 ++
 rtl/seq_delay_timer.sv | 26 ++
 rtl/counter_sweep_seq.sv | 161 ++++++++++++++++
 tb/tb_counter_sweep_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the counter sweep sequencer.
package counter_seq_pkg;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_GAP_CYC   = 4;
  localparam int DEF_SETTLE_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_PULSE = 3'd1,
    S_RST_GAP   = 3'd2,
    S_SETTLE    = 3'd3,
    S_SAMPLE    = 3'd4,
    S_ADV_PULSE = 3'd5,
    S_ADV_GAP   = 3'd6
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// Loadable down-counter with terminal-count flag; parks at zero until reloaded.
module seq_delay_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/counter_sweep_seq.sv
// Walks the external counters through reset, then COUNT advance steps,
// handing a settled sample request to the test FSM after each step.
//
// state       | meaning
// S_IDLE      | waiting for START
// S_RST_PULSE | RESET_COUNTER held for PULSE_CYC cycles
// S_RST_GAP   | idle gap after the reset pulse
// S_SETTLE    | waiting latched SETTLE cycles for counters to settle
// S_SAMPLE    | SAMPLE_REQ high until SAMPLE_ACK
// S_ADV_PULSE | ADVANCE_COUNTER held for PULSE_CYC cycles
// S_ADV_GAP   | idle gap after an advance pulse
module counter_sweep_seq
  import counter_seq_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int SETTLE_W  = DEF_SETTLE_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_count,
  input  logic [SETTLE_W-1:0] i_settle,
  input  logic                i_abort,
  input  logic                i_sample_ack,
  output logic                o_reset_counter,
  output logic                o_advance_counter,
  output logic                o_sample_req,
  output logic [CNT_W-1:0]    o_step,
  output logic                o_busy,
  output logic                o_done
);

  localparam int TMR_W = max2(SETTLE_W, $clog2(max2(PULSE_CYC, GAP_CYC)) + 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [SETTLE_W-1:0] r_settle;
  logic [CNT_W-1:0]    r_step;
  logic                r_abort_pend;
  logic                r_reset_counter;
  logic                r_advance_counter;
  logic                r_sample_req;
  logic                r_busy;
  logic                r_done;

  logic                w_tmr_zero;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_abort_seen;
  logic                w_rc_nxt;
  logic                w_ac_nxt;
  logic                w_req_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  seq_delay_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // An abort seen at any point in a pulse is remembered so the pulse can finish.
  assign w_abort_seen = r_abort_pend | i_abort;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_settle     <= '0;
      r_step       <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_abort_pend <= 1'b0;
      end else if ((r_state == S_RST_PULSE || r_state == S_ADV_PULSE) && i_abort) begin
        r_abort_pend <= 1'b1;
      end
      if (r_state == S_IDLE && w_state_nxt == S_RST_PULSE) begin
        r_count  <= i_count;
        r_settle <= i_settle;
        r_step   <= '0;
      end else if (r_state == S_ADV_PULSE && w_tmr_zero) begin
        r_step <= r_step + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) w_state_nxt = S_RST_PULSE;
      end
      S_RST_PULSE: begin
        if (w_tmr_zero) w_state_nxt = w_abort_seen ? S_IDLE : S_RST_GAP;
      end
      S_RST_GAP, S_ADV_GAP: begin
        if (i_abort)         w_state_nxt = S_IDLE;
        else if (w_tmr_zero) w_state_nxt = (r_settle == '0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (i_abort)         w_state_nxt = S_IDLE;
        else if (w_tmr_zero) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (i_abort)           w_state_nxt = S_IDLE;
        else if (i_sample_ack) w_state_nxt = (r_step == r_count) ? S_IDLE : S_ADV_PULSE;
      end
      S_ADV_PULSE: begin
        if (w_tmr_zero) w_state_nxt = w_abort_seen ? S_IDLE : S_ADV_GAP;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_tmr_load = (w_state_nxt != r_state);
    case (w_state_nxt)
      S_RST_PULSE, S_ADV_PULSE: w_tmr_val = TMR_W'(PULSE_CYC - 1);
      S_RST_GAP, S_ADV_GAP:     w_tmr_val = TMR_W'(GAP_CYC - 1);
      S_SETTLE:                 w_tmr_val = TMR_W'(r_settle) - TMR_W'(1);
      default:                  w_tmr_val = '0;
    endcase
  end

  always_comb begin
    w_rc_nxt   = (w_state_nxt == S_RST_PULSE);
    w_ac_nxt   = (w_state_nxt == S_ADV_PULSE);
    w_req_nxt  = (w_state_nxt == S_SAMPLE);
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (r_state == S_SAMPLE) && i_sample_ack && !i_abort && (r_step == r_count);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_reset_counter   <= 1'b0;
      r_advance_counter <= 1'b0;
      r_sample_req      <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      r_reset_counter   <= w_rc_nxt;
      r_advance_counter <= w_ac_nxt;
      r_sample_req      <= w_req_nxt;
      r_busy            <= w_busy_nxt;
      r_done            <= w_done_nxt;
    end
  end

  assign o_reset_counter   = r_reset_counter;
  assign o_advance_counter = r_advance_counter;
  assign o_sample_req      = r_sample_req;
  assign o_step            = r_step;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule

// File: tb/tb_counter_sweep_seq.sv
// Directed cycle-by-cycle bench for counter_sweep_seq with hand-derived timelines.
module tb_counter_sweep_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] count;
  logic [7:0]  settle;
  logic        abort_r;
  logic        ack;
  logic        rc;
  logic        ac;
  logic        req;
  logic [15:0] step;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  counter_sweep_seq dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_count           (count),
    .i_settle          (settle),
    .i_abort           (abort_r),
    .i_sample_ack      (ack),
    .o_reset_counter   (rc),
    .o_advance_counter (ac),
    .o_sample_req      (req),
    .o_step            (step),
    .o_busy            (busy),
    .o_done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_rc, input logic e_ac,
                            input logic e_req, input logic e_busy, input logic e_done,
                            input logic [15:0] e_step);
    chk({tag, " rc"},   32'(rc),   32'(e_rc));
    chk({tag, " ac"},   32'(ac),   32'(e_ac));
    chk({tag, " req"},  32'(req),  32'(e_req));
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
    chk({tag, " done"}, 32'(done), 32'(e_done));
    chk({tag, " step"}, 32'(step), 32'(e_step));
  endtask

  // Advance n edges, checking the expected outputs after each one.
  task automatic cyc(input int n, input logic e_rc, input logic e_ac, input logic e_req,
                     input logic e_busy, input logic e_done, input logic [15:0] e_step,
                     input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outs($sformatf("%s[%0d]", tag, i), e_rc, e_ac, e_req, e_busy, e_done, e_step);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; settle = '0; abort_r = 1'b0; ack = 1'b0;
    #2;
    check_outs("async_rst", 0, 0, 0, 0, 0, 16'd0);
    tick(); tick();
    check_outs("reset", 0, 0, 0, 0, 0, 16'd0);
    rst = 1'b0;
    cyc(2, 0, 0, 0, 0, 0, 16'd0, "idle");

    // Sweep COUNT=2 SETTLE=3, ACK in the first REQ cycle
    count = 16'd2; settle = 8'd3; start = 1'b1;
    cyc(1, 1, 0, 0, 1, 0, 16'd0, "t1_rst0");
    start = 1'b0;
    cyc(3, 1, 0, 0, 1, 0, 16'd0, "t1_rst");
    cyc(4, 0, 0, 0, 1, 0, 16'd0, "t1_rgap");
    cyc(3, 0, 0, 0, 1, 0, 16'd0, "t1_set0");
    cyc(1, 0, 0, 1, 1, 0, 16'd0, "t1_req0");
    ack = 1'b1;
    cyc(1, 0, 1, 0, 1, 0, 16'd0, "t1_adv0a");
    ack = 1'b0;
    cyc(3, 0, 1, 0, 1, 0, 16'd0, "t1_adv0");
    cyc(4, 0, 0, 0, 1, 0, 16'd1, "t1_agap1");
    cyc(3, 0, 0, 0, 1, 0, 16'd1, "t1_set1");
    cyc(1, 0, 0, 1, 1, 0, 16'd1, "t1_req1");
    ack = 1'b1;
    cyc(1, 0, 1, 0, 1, 0, 16'd1, "t1_adv1a");
    ack = 1'b0;
    cyc(3, 0, 1, 0, 1, 0, 16'd1, "t1_adv1");
    cyc(4, 0, 0, 0, 1, 0, 16'd2, "t1_agap2");
    cyc(3, 0, 0, 0, 1, 0, 16'd2, "t1_set2");
    cyc(1, 0, 0, 1, 1, 0, 16'd2, "t1_req2");
    ack = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 16'd2, "t1_done");
    ack = 1'b0;
    cyc(2, 0, 0, 0, 0, 0, 16'd2, "t1_idle");

    // COUNT=0 SETTLE=0: single sample straight after the reset gap
    count = 16'd0; settle = 8'd0; start = 1'b1;
    cyc(1, 1, 0, 0, 1, 0, 16'd0, "t2_rst0");
    start = 1'b0;
    cyc(3, 1, 0, 0, 1, 0, 16'd0, "t2_rst");
    cyc(4, 0, 0, 0, 1, 0, 16'd0, "t2_gap");
    cyc(1, 0, 0, 1, 1, 0, 16'd0, "t2_req");
    ack = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 16'd0, "t2_done");
    ack = 1'b0;
    cyc(2, 0, 0, 0, 0, 0, 16'd0, "t2_idle");

    // COUNT=3 SETTLE=1: delayed ACK, then ABORT in the 2nd ADV_PULSE cycle at STEP=1
    count = 16'd3; settle = 8'd1; start = 1'b1;
    cyc(1, 1, 0, 0, 1, 0, 16'd0, "t3_rst0");
    start = 1'b0;
    cyc(3, 1, 0, 0, 1, 0, 16'd0, "t3_rst");
    cyc(4, 0, 0, 0, 1, 0, 16'd0, "t3_gap");
    cyc(1, 0, 0, 0, 1, 0, 16'd0, "t3_set0");
    cyc(10, 0, 0, 1, 1, 0, 16'd0, "t3_reqhold");
    ack = 1'b1;
    cyc(1, 0, 1, 0, 1, 0, 16'd0, "t3_adv0a");
    ack = 1'b0;
    cyc(3, 0, 1, 0, 1, 0, 16'd0, "t3_adv0");
    cyc(4, 0, 0, 0, 1, 0, 16'd1, "t3_agap1");
    cyc(1, 0, 0, 0, 1, 0, 16'd1, "t3_set1");
    cyc(1, 0, 0, 1, 1, 0, 16'd1, "t3_req1");
    ack = 1'b1;
    cyc(1, 0, 1, 0, 1, 0, 16'd1, "t3_adv1a");
    ack = 1'b0; abort_r = 1'b1;
    cyc(3, 0, 1, 0, 1, 0, 16'd1, "t3_adv1ab");
    cyc(1, 0, 0, 0, 0, 0, 16'd2, "t3_aborted");
    abort_r = 1'b0;
    cyc(2, 0, 0, 0, 0, 0, 16'd2, "t3_idle");

    // START mid-SETTLE ignored, COUNT change mid-sweep ignored
    count = 16'd0; settle = 8'd5; start = 1'b1;
    cyc(1, 1, 0, 0, 1, 0, 16'd0, "t4_rst0");
    start = 1'b0;
    cyc(3, 1, 0, 0, 1, 0, 16'd0, "t4_rst");
    cyc(4, 0, 0, 0, 1, 0, 16'd0, "t4_gap");
    cyc(2, 0, 0, 0, 1, 0, 16'd0, "t4_seta");
    start = 1'b1; count = 16'd7; settle = 8'd0;
    cyc(3, 0, 0, 0, 1, 0, 16'd0, "t4_setb");
    start = 1'b0;
    cyc(1, 0, 0, 1, 1, 0, 16'd0, "t4_req");
    ack = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 16'd0, "t4_done");
    ack = 1'b0;

    // START and ABORT together in IDLE: stay idle
    start = 1'b1; abort_r = 1'b1;
    cyc(3, 0, 0, 0, 0, 0, 16'd0, "t5_startabort");
    start = 1'b0; abort_r = 1'b0;

    // Async reset mid-SETTLE at STEP=1, then a normal sweep
    count = 16'd1; settle = 8'd4; start = 1'b1;
    cyc(1, 1, 0, 0, 1, 0, 16'd0, "t6_rst0");
    start = 1'b0;
    cyc(3, 1, 0, 0, 1, 0, 16'd0, "t6_rst");
    cyc(4, 0, 0, 0, 1, 0, 16'd0, "t6_gap");
    cyc(4, 0, 0, 0, 1, 0, 16'd0, "t6_set0");
    cyc(1, 0, 0, 1, 1, 0, 16'd0, "t6_req0");
    ack = 1'b1;
    cyc(1, 0, 1, 0, 1, 0, 16'd0, "t6_adv0a");
    ack = 1'b0;
    cyc(3, 0, 1, 0, 1, 0, 16'd0, "t6_adv0");
    cyc(4, 0, 0, 0, 1, 0, 16'd1, "t6_agap1");
    cyc(2, 0, 0, 0, 1, 0, 16'd1, "t6_set1");
    #2 rst = 1'b1;
    #1 check_outs("t6_asyncrst", 0, 0, 0, 0, 0, 16'd0);
    #2 rst = 1'b0;
    count = 16'd0; settle = 8'd0; start = 1'b1;
    cyc(1, 1, 0, 0, 1, 0, 16'd0, "t6_re_rst0");
    start = 1'b0;
    cyc(3, 1, 0, 0, 1, 0, 16'd0, "t6_re_rst");
    cyc(4, 0, 0, 0, 1, 0, 16'd0, "t6_re_gap");
    cyc(1, 0, 0, 1, 1, 0, 16'd0, "t6_re_req");
    ack = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 16'd0, "t6_re_done");
    ack = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 16'd0, "t6_re_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
